cpu_sequencer: RTL and testbench

Micro-sequencer for the 8-bit CPU core. Generates the 8-bit `state` word that the control-signal decoder turns into datapath strobes (PC, IR, register file, ALU, MAR/RAM, stack pointer). Walks every instruction through a common fetch/decode prologue, then a per-class execute sequence, and parks in HALT on `HLT` or on an illegal opcode.

---
 rtl/cpu_sequencer_pkg.sv | 95 +++++++++
 rtl/cpu_sequencer_seq_rom.sv | 123 ++++++++++++
 rtl/cpu_sequencer.sv | 87 ++++++++
 tb/tb_cpu_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Shared symbols for the 8-bit CPU micro-sequencer:
// state codes, instruction field codes and sequence ids.
package cpu_sequencer_pkg;

   localparam logic [7:0] STATE_FETCH_PC   = 8'h00;
   localparam logic [7:0] STATE_FETCH_INST = 8'h01;
   localparam logic [7:0] STATE_SET_MAR    = 8'h02;
   localparam logic [7:0] STATE_MOV_REG    = 8'h03;
   localparam logic [7:0] STATE_ALU_EXEC   = 8'h04;
   localparam logic [7:0] STATE_ALU_OUT    = 8'h05;
   localparam logic [7:0] STATE_SET_REG    = 8'h06;
   localparam logic [7:0] STATE_LOAD_ADDR  = 8'h07;
   localparam logic [7:0] STATE_SET_MEM    = 8'h08;
   localparam logic [7:0] STATE_FETCH_SP   = 8'h09;
   localparam logic [7:0] STATE_STACK_REG  = 8'h0A;
   localparam logic [7:0] STATE_INC_SP     = 8'h0B;
   localparam logic [7:0] STATE_STORE_PC   = 8'h0C;
   localparam logic [7:0] STATE_TMP_JUMP   = 8'h0D;
   localparam logic [7:0] STATE_JUMP       = 8'h0E;
   localparam logic [7:0] STATE_RET        = 8'h0F;
   localparam logic [7:0] STATE_HALT       = 8'hFF;

   localparam logic [1:0] CLS_MOV = 2'b00;
   localparam logic [1:0] CLS_ALU = 2'b01;
   localparam logic [1:0] CLS_MEM = 2'b10;
   localparam logic [1:0] CLS_CTL = 2'b11;

   localparam logic [2:0] MEM_LDI  = 3'b000;
   localparam logic [2:0] MEM_LD   = 3'b001;
   localparam logic [2:0] MEM_ST   = 3'b010;
   localparam logic [2:0] MEM_PUSH = 3'b011;
   localparam logic [2:0] MEM_POP  = 3'b100;

   localparam logic [2:0] CTL_JCC  = 3'b000;
   localparam logic [2:0] CTL_CALL = 3'b001;
   localparam logic [2:0] CTL_RET  = 3'b010;
   localparam logic [2:0] CTL_HLT  = 3'b111;

   typedef enum logic [3:0] {
      SEQ_MOV  = 4'd0,
      SEQ_ALU  = 4'd1,
      SEQ_LDI  = 4'd2,
      SEQ_LD   = 4'd3,
      SEQ_ST   = 4'd4,
      SEQ_PUSH = 4'd5,
      SEQ_POP  = 4'd6,
      SEQ_JCC  = 4'd7,
      SEQ_CALL = 4'd8,
      SEQ_RET  = 4'd9,
      SEQ_HALT = 4'd15
   } seq_e;

   typedef enum logic {
      PH_PRO = 1'b0,
      PH_EXE = 1'b1
   } phase_e;

   // HLT and every unassigned encoding both collapse onto SEQ_HALT.
   function automatic seq_e decode_seq(input logic [7:0] instr);
      logic [1:0] cls;
      logic [2:0] op2;
      logic [2:0] op1;
      seq_e       s;
      cls = instr[7:6];
      op2 = instr[5:3];
      op1 = instr[2:0];
      s   = SEQ_HALT;
      case (cls)
         CLS_MOV: s = SEQ_MOV;
         CLS_ALU: s = SEQ_ALU;
         CLS_MEM: begin
            case (op2)
               MEM_LDI:  s = SEQ_LDI;
               MEM_LD:   s = SEQ_LD;
               MEM_ST:   s = SEQ_ST;
               MEM_PUSH: s = SEQ_PUSH;
               MEM_POP:  s = SEQ_POP;
               default:  s = SEQ_HALT;
            endcase
         end
         CLS_CTL: begin
            case (op1)
               CTL_JCC:  s = SEQ_JCC;
               CTL_CALL: s = SEQ_CALL;
               CTL_RET:  s = SEQ_RET;
               CTL_HLT:  s = SEQ_HALT;
               default:  s = SEQ_HALT;
            endcase
         end
         default: s = SEQ_HALT;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/cpu_sequencer_seq_rom.sv
// Execute-sequence table: (sequence id, step) -> (state code, last flag).
// Purely combinational; the halt sequence never reports a last step.
module seq_rom
   import cpu_sequencer_pkg::*;
(
   input  seq_e       seq,
   input  logic [2:0] step,
   output logic [7:0] code,
   output logic       last
);

   always_comb begin
      code = STATE_HALT;
      last = 1'b0;
      case (seq)
         SEQ_MOV: begin
            code = STATE_MOV_REG;
            last = 1'b1;
         end
         SEQ_ALU: begin
            case (step)
               3'd0: code = STATE_ALU_EXEC;
               3'd1: begin
                  code = STATE_ALU_OUT;
                  last = 1'b1;
               end
               default: ;
            endcase
         end
         SEQ_LDI: begin
            case (step)
               3'd0: code = STATE_FETCH_PC;
               3'd1: begin
                  code = STATE_SET_REG;
                  last = 1'b1;
               end
               default: ;
            endcase
         end
         SEQ_LD: begin
            case (step)
               3'd0: code = STATE_FETCH_PC;
               3'd1: code = STATE_LOAD_ADDR;
               3'd2: begin
                  code = STATE_SET_REG;
                  last = 1'b1;
               end
               default: ;
            endcase
         end
         SEQ_ST: begin
            case (step)
               3'd0: code = STATE_FETCH_PC;
               3'd1: code = STATE_LOAD_ADDR;
               3'd2: begin
                  code = STATE_SET_MEM;
                  last = 1'b1;
               end
               default: ;
            endcase
         end
         SEQ_PUSH: begin
            case (step)
               3'd0: code = STATE_FETCH_SP;
               3'd1: begin
                  code = STATE_STACK_REG;
                  last = 1'b1;
               end
               default: ;
            endcase
         end
         SEQ_POP: begin
            case (step)
               3'd0: code = STATE_INC_SP;
               3'd1: code = STATE_FETCH_SP;
               3'd2: begin
                  code = STATE_SET_REG;
                  last = 1'b1;
               end
               default: ;
            endcase
         end
         SEQ_JCC: begin
            case (step)
               3'd0: code = STATE_FETCH_PC;
               3'd1: begin
                  code = STATE_JUMP;
                  last = 1'b1;
               end
               default: ;
            endcase
         end
         SEQ_CALL: begin
            case (step)
               3'd0: code = STATE_FETCH_SP;
               3'd1: code = STATE_STORE_PC;
               3'd2: code = STATE_FETCH_PC;
               3'd3: begin
                  code = STATE_TMP_JUMP;
                  last = 1'b1;
               end
               default: ;
            endcase
         end
         SEQ_RET: begin
            case (step)
               3'd0: code = STATE_INC_SP;
               3'd1: code = STATE_FETCH_SP;
               3'd2: begin
                  code = STATE_RET;
                  last = 1'b1;
               end
               default: ;
            endcase
         end
         default: begin
            code = STATE_HALT;
            last = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/cpu_sequencer.sv
// Micro-sequencer top: fetch/decode prologue, per-class execute
// sequences from seq_rom, absorbing HALT, step enable.
module cpu_sequencer
   import cpu_sequencer_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] instr,
   output logic [7:0] state,
   output logic       halted,
   output logic       retire
);

   logic [7:0] state_d, state_q;
   logic [2:0] step_d, step_q;
   logic       last_d, last_q;
   seq_e       seq_d, seq_q;
   phase_e     phase_d, phase_q;

   logic [7:0] rom_code;
   logic       rom_last;

   // Looked up on the next (seq, step) so state and last leave flops.
   seq_rom u_seq_rom (
      .seq  (seq_d),
      .step (step_d),
      .code (rom_code),
      .last (rom_last)
   );

   always_comb begin
      seq_d   = seq_q;
      step_d  = step_q;
      phase_d = phase_q;
      if (en && (state_q != STATE_HALT)) begin
         if (phase_q == PH_PRO) begin
            if (step_q == 3'd2) begin
               seq_d   = decode_seq(instr);
               step_d  = 3'd0;
               phase_d = PH_EXE;
            end else begin
               step_d = step_q + 3'd1;
            end
         end else if (last_q) begin
            step_d  = 3'd0;
            phase_d = PH_PRO;
         end else begin
            step_d = step_q + 3'd1;
         end
      end
   end

   always_comb begin
      state_d = rom_code;
      last_d  = rom_last;
      if (phase_d == PH_PRO) begin
         last_d = 1'b0;
         case (step_d)
            3'd0:    state_d = STATE_FETCH_PC;
            3'd1:    state_d = STATE_FETCH_INST;
            default: state_d = STATE_SET_MAR;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= STATE_FETCH_PC;
         step_q  <= 3'd0;
         last_q  <= 1'b0;
         seq_q   <= SEQ_MOV;
         phase_q <= PH_PRO;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         last_q  <= last_d;
         seq_q   <= seq_d;
         phase_q <= phase_d;
      end
   end

   assign state  = state_q;
   assign halted = (state_q == STATE_HALT);
   assign retire = en && (phase_q == PH_EXE) && last_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: vector table per cycle
// plus hand-written halt, enable-hold and async-reset sequences.
module tb_cpu_sequencer;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] instr;
   logic [7:0] state;
   logic       halted;
   logic       retire;

   int total;
   int bad;

   typedef struct {
      logic       en;
      logic [7:0] instr;
      logic [7:0] st;
      logic       ret;
      logic       hlt;
   } vec_t;

   vec_t vecs[$];

   cpu_sequencer dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .instr  (instr),
      .state  (state),
      .halted (halted),
      .retire (retire)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int idx,
                      input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
      end
   endtask

   task automatic chk_out(input string nm, input int idx,
                          input logic [7:0] st, input logic ret,
                          input logic hlt);
      chk({nm, ".state"}, idx, state, st);
      chk({nm, ".retire"}, idx, {7'd0, retire}, {7'd0, ret});
      chk({nm, ".halted"}, idx, {7'd0, halted}, {7'd0, hlt});
   endtask

   // Drive one cycle's inputs, check outputs, then advance one clock.
   task automatic step(input string nm, input int idx, input logic e,
                       input logic [7:0] ins, input logic [7:0] st,
                       input logic ret, input logic hlt);
      en    = e;
      instr = ins;
      #1;
      chk_out(nm, idx, st, ret, hlt);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      en    = 1'b0;
      #1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic add(input logic e, input logic [7:0] ins,
                      input logic [7:0] st, input logic ret);
      vec_t v;
      v.en    = e;
      v.instr = ins;
      v.st    = st;
      v.ret   = ret;
      v.hlt   = 1'b0;
      vecs.push_back(v);
   endtask

   task automatic add_pro(input logic [7:0] ins);
      add(1'b1, 8'hFF, 8'h00, 1'b0);
      add(1'b1, 8'h3C, 8'h01, 1'b0);
      add(1'b1, ins, 8'h02, 1'b0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      en    = 1'b0;
      instr = 8'h00;
      #3;
      chk_out("reset", 0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // MOV 0A
      add_pro(8'h0A);
      add(1'b1, 8'h00, 8'h03, 1'b1);
      // ALU 40
      add_pro(8'h40);
      add(1'b1, 8'h00, 8'h04, 1'b0);
      add(1'b1, 8'h00, 8'h05, 1'b1);
      // LDI 80
      add_pro(8'h80);
      add(1'b1, 8'h00, 8'h00, 1'b0);
      add(1'b1, 8'h00, 8'h06, 1'b1);
      // LD 88
      add_pro(8'h88);
      add(1'b1, 8'h00, 8'h00, 1'b0);
      add(1'b1, 8'h00, 8'h07, 1'b0);
      add(1'b1, 8'h00, 8'h06, 1'b1);
      // ST 90
      add_pro(8'h90);
      add(1'b1, 8'hC7, 8'h00, 1'b0);
      add(1'b1, 8'hC7, 8'h07, 1'b0);
      add(1'b1, 8'hC7, 8'h08, 1'b1);
      // PUSH 98
      add_pro(8'h98);
      add(1'b1, 8'h00, 8'h09, 1'b0);
      add(1'b1, 8'h00, 8'h0A, 1'b1);
      // POP A0
      add_pro(8'hA0);
      add(1'b1, 8'h00, 8'h0B, 1'b0);
      add(1'b1, 8'h00, 8'h09, 1'b0);
      add(1'b1, 8'h00, 8'h06, 1'b1);
      // Jcc E8 (cond 101)
      add_pro(8'hE8);
      add(1'b1, 8'h00, 8'h00, 1'b0);
      add(1'b1, 8'h00, 8'h0E, 1'b1);
      // CALL C1
      add_pro(8'hC1);
      add(1'b1, 8'h00, 8'h09, 1'b0);
      add(1'b1, 8'h00, 8'h0C, 1'b0);
      add(1'b1, 8'h00, 8'h00, 1'b0);
      add(1'b1, 8'h00, 8'h0D, 1'b1);
      // RET C2, with en low on the last step
      add_pro(8'hC2);
      add(1'b1, 8'h00, 8'h0B, 1'b0);
      add(1'b1, 8'h00, 8'h09, 1'b0);
      add(1'b0, 8'h00, 8'h0F, 1'b0);
      add(1'b1, 8'h00, 8'h0F, 1'b1);
      // en low in SET_MAR: decode uses instr at the enabled edge
      add(1'b1, 8'h00, 8'h00, 1'b0);
      add(1'b1, 8'h00, 8'h01, 1'b0);
      add(1'b0, 8'hC2, 8'h02, 1'b0);
      add(1'b0, 8'hC7, 8'h02, 1'b0);
      add(1'b1, 8'h40, 8'h02, 1'b0);
      add(1'b1, 8'hC7, 8'h04, 1'b0);
      add(1'b1, 8'hC7, 8'h05, 1'b1);
      add(1'b1, 8'h00, 8'h00, 1'b0);

      foreach (vecs[i])
         step("vec", i, vecs[i].en, vecs[i].instr, vecs[i].st,
              vecs[i].ret, vecs[i].hlt);

      // HLT: absorbing regardless of en, left only by reset
      do_reset();
      step("hlt", 0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
      step("hlt", 1, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0);
      step("hlt", 2, 1'b1, 8'hC7, 8'h02, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++)
         step("hlt_hold", i, logic'(i % 2 == 0), 8'h0A,
              8'hFF, 1'b0, 1'b1);
      rst_n = 1'b0;
      #1;
      chk_out("hlt_rst", 0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      step("hlt_rst", 1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
      step("hlt_rst", 2, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0);

      // Illegal class 10 op2=101
      do_reset();
      step("ill", 0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
      step("ill", 1, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0);
      step("ill", 2, 1'b1, 8'hA8, 8'h02, 1'b0, 1'b0);
      for (int i = 3; i < 7; i++)
         step("ill", i, 1'b1, 8'h0A, 8'hFF, 1'b0, 1'b1);

      // LD stalled at LOAD_ADDR, then async reset mid-cycle
      do_reset();
      step("ldrst", 0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
      step("ldrst", 1, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0);
      step("ldrst", 2, 1'b1, 8'h88, 8'h02, 1'b0, 1'b0);
      step("ldrst", 3, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
      for (int i = 4; i < 7; i++)
         step("ldrst", i, 1'b0, 8'h00, 8'h07, 1'b0, 1'b0);
      en = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk_out("ldrst_async", 0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      step("ldrst", 7, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
      step("ldrst", 8, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0);
      step("ldrst", 9, 1'b1, 8'h0A, 8'h02, 1'b0, 1'b0);
      step("ldrst", 10, 1'b1, 8'h00, 8'h03, 1'b1, 1'b0);
      step("ldrst", 11, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
